// File: rtl/vsa_param_core.sv
`default_nettype none
// ============================================================================
// Module   : vsa_param_core
// Brief    : Parametrised five-state multicycle LW/SW/BEQZ/BNEZ/ALU core with
//            instruction/data ready handshakes, retire pulse and a register
//            file debug read port.
// Revision : 1.0 - initial release
// ============================================================================
module vsa_param_core #(
    parameter  int DW    = 5,
    parameter  int AW    = 2,
    parameter  int PCW   = 5,
    parameter  int SEXT  = 0,
    localparam int c_IW  = 6 + 3 * AW,
    localparam int c_IMW = AW + 3
) (
    input  logic             i_clk,
    input  logic             i_rst,
    output logic [PCW-1:0]   o_pc,
    input  logic [c_IW-1:0]  i_instruction,
    input  logic             i_imem_ready,
    output logic [DW-1:0]    o_alu_out,
    input  logic [DW-1:0]    i_datain,
    output logic [DW-1:0]    o_dataout,
    output logic             o_wr,
    output logic             o_rd,
    input  logic             i_mem_ready,
    output logic             o_retire,
    input  logic [AW-1:0]    i_dbg_addr,
    output logic [DW-1:0]    o_dbg_data
);

    localparam int c_NREG = 1 << AW;

    // Opcodes
    localparam logic [2:0] c_OP_LW   = 3'd0;
    localparam logic [2:0] c_OP_SW   = 3'd1;
    localparam logic [2:0] c_OP_BEQZ = 3'd2;
    localparam logic [2:0] c_OP_ALU  = 3'd3;
    localparam logic [2:0] c_OP_ADDI = 3'd4;
    localparam logic [2:0] c_OP_SUBI = 3'd5;
    localparam logic [2:0] c_OP_BNEZ = 3'd6;

    // ALU function codes
    localparam logic [2:0] c_FN_ADD  = 3'd0;
    localparam logic [2:0] c_FN_SUB  = 3'd1;
    localparam logic [2:0] c_FN_AND  = 3'd2;
    localparam logic [2:0] c_FN_OR   = 3'd3;
    localparam logic [2:0] c_FN_XOR  = 3'd4;
    localparam logic [2:0] c_FN_NOT  = 3'd5;
    localparam logic [2:0] c_FN_SRL  = 3'd6;

    typedef enum logic [2:0] {
        S_IF  = 3'd0,
        S_ID  = 3'd1,
        S_EX  = 3'd2,
        S_MEM = 3'd3,
        S_WB  = 3'd4
    } state_t;

    state_t              r_state;
    state_t              w_state_next;

    logic [PCW-1:0]      r_pc;
    logic [PCW-1:0]      r_npc;
    logic [c_IW-1:0]     r_ir;
    logic [DW-1:0]       r_a;
    logic [DW-1:0]       r_b;
    logic [DW-1:0]       r_alu_out;
    logic [DW-1:0]       r_lmd;
    logic                r_cond;
    logic [DW-1:0]       r_regs [c_NREG];

    // Instruction fields. The I-format destination shares the R-format src2
    // slot, so B always holds the store data register for SW.
    logic [2:0]          w_op;
    logic [AW-1:0]       w_src1;
    logic [AW-1:0]       w_src2;
    logic [AW-1:0]       w_rdst;
    logic [2:0]          w_fun;
    logic [c_IMW-1:0]    w_imm;
    logic [DW-1:0]       w_imm_ext;
    logic [c_IMW-1:0]    w_boff;
    logic [PCW-1:0]      w_target;
    logic                w_is_mem;
    logic                w_is_branch;

    logic [DW-1:0]       w_rf_a;
    logic [DW-1:0]       w_rf_b;
    logic [DW-1:0]       w_alu_res;
    logic signed [DW-1:0] w_a_s;
    logic                w_cond;

    logic                w_rf_we;
    logic [AW-1:0]       w_rf_waddr;
    logic [DW-1:0]       w_rf_wdata;

    logic                w_wr;
    logic                w_rd;
    logic                w_retire;

    assign w_op        = r_ir[c_IW-1 -: 3];
    assign w_src1      = r_ir[c_IW-4 -: AW];
    assign w_src2      = r_ir[c_IW-4-AW -: AW];
    assign w_rdst      = r_ir[c_IW-4-2*AW -: AW];
    assign w_fun       = r_ir[2:0];
    assign w_imm       = r_ir[c_IMW-1:0];
    assign w_is_mem    = (w_op == c_OP_LW) || (w_op == c_OP_SW);
    assign w_is_branch = (w_op == c_OP_BEQZ) || (w_op == c_OP_BNEZ);

    // Immediate extension is fixed at elaboration time.
    generate
        if (SEXT != 0) begin : g_imm_sext
            assign w_imm_ext = DW'($signed(w_imm));
        end else begin : g_imm_zext
            assign w_imm_ext = DW'(w_imm);
        end
    endgenerate

    // Branch offset is the immediate without its top bit, in half-words;
    // the sum wraps naturally at PCW bits.
    assign w_boff   = {w_imm[c_IMW-2:0], 1'b0};
    assign w_target = r_npc + PCW'(w_boff);

    // R0 is hard-wired to zero on every read path.
    assign w_rf_a     = (w_src1 == '0) ? '0 : r_regs[w_src1];
    assign w_rf_b     = (w_src2 == '0) ? '0 : r_regs[w_src2];
    assign o_dbg_data = (i_dbg_addr == '0) ? '0 : r_regs[i_dbg_addr];

    assign w_a_s  = r_a;
    assign w_cond = (w_op == c_OP_BEQZ) ? (r_a == '0) : (r_a != '0);

    // EX result; NOP (and anything unlisted) leaves alu_out unchanged.
    always_comb begin
        w_alu_res = r_alu_out;
        case (w_op)
            c_OP_LW, c_OP_SW, c_OP_ADDI: w_alu_res = r_a + w_imm_ext;
            c_OP_SUBI:                   w_alu_res = r_a - w_imm_ext;
            c_OP_BEQZ, c_OP_BNEZ:        w_alu_res = DW'(w_target);
            c_OP_ALU: begin
                case (w_fun)
                    c_FN_ADD: w_alu_res = r_a + r_b;
                    c_FN_SUB: w_alu_res = r_a - r_b;
                    c_FN_AND: w_alu_res = r_a & r_b;
                    c_FN_OR:  w_alu_res = r_a | r_b;
                    c_FN_XOR: w_alu_res = r_a ^ r_b;
                    c_FN_NOT: w_alu_res = ~r_a;
                    c_FN_SRL: w_alu_res = r_a >> 1;
                    default:  w_alu_res = w_a_s >>> 1;
                endcase
            end
            default: w_alu_res = r_alu_out;
        endcase
    end

    // Write-back selection; writes to R0 are dropped here.
    always_comb begin
        w_rf_we    = 1'b0;
        w_rf_waddr = w_src2;
        w_rf_wdata = r_alu_out;
        if (r_state == S_WB) begin
            case (w_op)
                c_OP_ALU: begin
                    w_rf_we    = 1'b1;
                    w_rf_waddr = w_rdst;
                end
                c_OP_ADDI, c_OP_SUBI: w_rf_we = 1'b1;
                c_OP_LW: begin
                    w_rf_we    = 1'b1;
                    w_rf_wdata = r_lmd;
                end
                default: w_rf_we = 1'b0;
            endcase
        end
        if (w_rf_waddr == '0) begin
            w_rf_we = 1'b0;
        end
    end

    // State register.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state <= S_IF;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state and memory/retire strobes; illegal encodings fall back to IF.
    always_comb begin
        w_state_next = S_IF;
        w_wr         = 1'b0;
        w_rd         = 1'b0;
        w_retire     = 1'b0;
        case (r_state)
            S_IF:  w_state_next = i_imem_ready ? S_ID : S_IF;
            S_ID:  w_state_next = S_EX;
            S_EX:  w_state_next = S_MEM;
            S_MEM: begin
                if (w_is_mem) begin
                    w_rd         = (w_op == c_OP_LW);
                    w_wr         = (w_op == c_OP_SW);
                    w_state_next = i_mem_ready ? S_WB : S_MEM;
                end else begin
                    w_state_next = S_WB;
                end
            end
            S_WB: begin
                w_retire     = 1'b1;
                w_state_next = S_IF;
            end
            default: w_state_next = S_IF;
        endcase
    end

    // Datapath registers, each loaded only in its own pipeline phase.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_pc      <= '0;
            r_npc     <= '0;
            r_ir      <= '0;
            r_a       <= '0;
            r_b       <= '0;
            r_alu_out <= '0;
            r_lmd     <= '0;
            r_cond    <= 1'b0;
        end else begin
            case (r_state)
                S_IF: begin
                    if (i_imem_ready) begin
                        r_ir  <= i_instruction;
                        r_npc <= r_pc + PCW'(2);
                    end
                end
                S_ID: begin
                    r_a <= w_rf_a;
                    r_b <= w_rf_b;
                end
                S_EX: begin
                    r_alu_out <= w_alu_res;
                    if (w_is_branch) begin
                        r_cond <= w_cond;
                    end
                end
                S_MEM: begin
                    if (w_is_mem) begin
                        if (i_mem_ready) begin
                            if (w_op == c_OP_LW) begin
                                r_lmd <= i_datain;
                            end
                            r_pc <= r_npc;
                        end
                    end else if (w_is_branch && r_cond) begin
                        r_pc <= PCW'(r_alu_out);
                    end else begin
                        r_pc <= r_npc;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Register file storage.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            for (int i = 0; i < c_NREG; i++) begin
                r_regs[i] <= '0;
            end
        end else if (w_rf_we) begin
            r_regs[w_rf_waddr] <= w_rf_wdata;
        end
    end

    assign o_pc      = r_pc;
    assign o_alu_out = r_alu_out;
    assign o_dataout = r_b;
    assign o_wr      = w_wr;
    assign o_rd      = w_rd;
    assign o_retire  = w_retire;

endmodule
`default_nettype wire

// File: tb/tb_vsa_param_core.sv
`default_nettype none
// ============================================================================
// Module   : tb_vsa_param_core
// Brief    : Self-checking bench for vsa_param_core: directed scenarios plus
//            randomized instructions against an architectural model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_vsa_param_core;

    localparam int DW  = 5;
    localparam int AW  = 2;
    localparam int PCW = 5;
    localparam int IW  = 12;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic [IW-1:0]  instruction = '0;
    logic           imem_ready = 1'b0;
    logic           mem_ready = 1'b0;
    logic [DW-1:0]  datain = '0;
    logic [AW-1:0]  dbg_addr = '0;

    logic [PCW-1:0] pc;
    logic [DW-1:0]  alu_out, dataout, dbg_data;
    logic           wr, rd, retire;

    logic [PCW-1:0] sx_pc;
    logic [DW-1:0]  sx_alu_out, sx_dataout, sx_dbg_data;
    logic           sx_wr, sx_rd, sx_retire;

    logic [PCW-1:0] w8_pc;
    logic [7:0]     w8_alu_out, w8_dataout, w8_dbg_data;
    logic           w8_wr, w8_rd, w8_retire;

    int checks = 0;
    int failures = 0;
    int retire_cnt = 0;
    int wr_cnt = 0;
    int cyc = 0;

    // Architectural model state
    int m_regs [4];
    int m_pc;
    int m_alu;

    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc++;
        if (retire === 1'b1) retire_cnt++;
        if (wr === 1'b1) wr_cnt++;
    end

    vsa_param_core #(.DW(DW), .AW(AW), .PCW(PCW), .SEXT(0)) u_dut (
        .i_clk(clk), .i_rst(rst), .o_pc(pc), .i_instruction(instruction),
        .i_imem_ready(imem_ready), .o_alu_out(alu_out), .i_datain(datain),
        .o_dataout(dataout), .o_wr(wr), .o_rd(rd), .i_mem_ready(mem_ready),
        .o_retire(retire), .i_dbg_addr(dbg_addr), .o_dbg_data(dbg_data)
    );

    vsa_param_core #(.DW(5), .AW(AW), .PCW(PCW), .SEXT(1)) u_sx (
        .i_clk(clk), .i_rst(rst), .o_pc(sx_pc), .i_instruction(instruction),
        .i_imem_ready(imem_ready), .o_alu_out(sx_alu_out), .i_datain(datain),
        .o_dataout(sx_dataout), .o_wr(sx_wr), .o_rd(sx_rd), .i_mem_ready(mem_ready),
        .o_retire(sx_retire), .i_dbg_addr(dbg_addr), .o_dbg_data(sx_dbg_data)
    );

    vsa_param_core #(.DW(8), .AW(AW), .PCW(PCW), .SEXT(0)) u_w8 (
        .i_clk(clk), .i_rst(rst), .o_pc(w8_pc), .i_instruction(instruction),
        .i_imem_ready(imem_ready), .o_alu_out(w8_alu_out), .i_datain({3'b000, datain}),
        .o_dataout(w8_dataout), .o_wr(w8_wr), .o_rd(w8_rd), .i_mem_ready(mem_ready),
        .o_retire(w8_retire), .i_dbg_addr(dbg_addr), .o_dbg_data(w8_dbg_data)
    );

    task automatic model_clear();
        for (int r = 0; r < 4; r++) m_regs[r] = 0;
        m_pc  = 0;
        m_alu = 0;
    endtask

    // Leaves the DUT in IF, 1 ns after a rising edge.
    task automatic do_reset();
        rst = 1'b1; imem_ready = 1'b0; mem_ready = 1'b0; instruction = '0; datain = '0;
        @(posedge clk); #1;
        rst = 1'b0;
        model_clear();
    endtask

    // Runs one instruction from IF to the following IF, checking every phase
    // against the architectural model. Entered and left 1 ns after an edge.
    task automatic run_instr(input logic [11:0] ins, input int n_if, input int n_mem, input int ld_val);
        int op, s1, f2, rdd, fn, imm, a, b, npc, res, wreg, wval, newpc, rc0;
        op = int'(ins[11:9]); s1 = int'(ins[8:7]); f2 = int'(ins[6:5]);
        rdd = int'(ins[4:3]); fn = int'(ins[2:0]); imm = int'(ins[4:0]);
        ld_val = ld_val & 31;
        a = m_regs[s1]; b = m_regs[f2];
        npc = (m_pc + 2) % 32;
        res = m_alu; wreg = 0; wval = 0; newpc = npc;
        case (op)
            0: begin res = (a + imm) & 31; wreg = f2; wval = ld_val; end
            1: res = (a + imm) & 31;
            2: begin res = (npc + 2 * (imm & 15)) & 31; if (a == 0) newpc = res; end
            3: begin
                case (fn)
                    0: res = (a + b) & 31;
                    1: res = (a - b) & 31;
                    2: res = a & b;
                    3: res = a | b;
                    4: res = a ^ b;
                    5: res = (~a) & 31;
                    6: res = a / 2;
                    default: res = (a / 2) | (a & 16);
                endcase
                wreg = rdd; wval = res;
            end
            4: begin res = (a + imm) & 31; wreg = f2; wval = res; end
            5: begin res = (a - imm) & 31; wreg = f2; wval = res; end
            6: begin res = (npc + 2 * (imm & 15)) & 31; if (a != 0) newpc = res; end
            default: ;
        endcase
        rc0 = retire_cnt;

        // IF: architectural state visible before fetch
        checks++; if (pc !== PCW'(m_pc)) begin failures++; $display("FAIL if_pc: got %0h exp %0h", pc, m_pc); end
        checks++; if (retire !== 1'b0) begin failures++; $display("FAIL if_retire: got %b exp 0", retire); end
        for (int r = 0; r < 4; r++) begin
            dbg_addr = AW'(r); #1;
            checks++; if (dbg_data !== DW'(m_regs[r])) begin failures++; $display("FAIL dbg_R%0d: got %0h exp %0h", r, dbg_data, m_regs[r]); end
        end
        imem_ready = 1'b0; instruction = IW'($urandom);
        repeat (n_if) begin @(posedge clk); #1; instruction = IW'($urandom); end
        instruction = ins; imem_ready = 1'b1;
        @(posedge clk); #1;                                  // ID
        imem_ready = 1'($urandom); instruction = IW'($urandom);
        @(posedge clk); #1;                                  // EX
        imem_ready = 1'b0;
        @(posedge clk); #1;                                  // MEM
        if (op <= 1) begin
            for (int k = 0; k <= n_mem; k++) begin
                mem_ready = (k == n_mem);
                datain = (k == n_mem) ? DW'(ld_val) : DW'($urandom);
                checks++; if (rd !== (op == 0)) begin failures++; $display("FAIL mem_rd: got %b exp %b ins %h", rd, op == 0, ins); end
                checks++; if (wr !== (op == 1)) begin failures++; $display("FAIL mem_wr: got %b exp %b ins %h", wr, op == 1, ins); end
                checks++; if (alu_out !== DW'(res)) begin failures++; $display("FAIL mem_addr: got %0h exp %0h ins %h", alu_out, res, ins); end
                if (op == 1) begin
                    checks++; if (dataout !== DW'(b)) begin failures++; $display("FAIL sw_data: got %0h exp %0h", dataout, b); end
                end
                @(posedge clk); #1;
            end
        end else begin
            mem_ready = 1'($urandom);
            checks++; if ({rd, wr} !== 2'b00) begin failures++; $display("FAIL strobe_idle: got %b%b exp 00 ins %h", rd, wr, ins); end
            checks++; if (alu_out !== DW'(res)) begin failures++; $display("FAIL ex_result: got %0h exp %0h ins %h", alu_out, res, ins); end
            @(posedge clk); #1;
        end
        // WB
        mem_ready = 1'b0; imem_ready = 1'b0;
        checks++; if (retire !== 1'b1) begin failures++; $display("FAIL wb_retire: got %b exp 1 ins %h", retire, ins); end
        checks++; if (pc !== PCW'(newpc)) begin failures++; $display("FAIL wb_pc: got %0h exp %0h ins %h", pc, newpc, ins); end
        checks++; if ({rd, wr} !== 2'b00) begin failures++; $display("FAIL wb_strobe: got %b%b exp 00", rd, wr); end
        @(posedge clk); #1;                                  // IF
        checks++; if (retire_cnt - rc0 !== 1) begin failures++; $display("FAIL retire_count: got %0d exp 1 ins %h", retire_cnt - rc0, ins); end
        if (wreg != 0) m_regs[wreg] = wval;
        m_pc = newpc; m_alu = res;
    endtask

    task automatic test_reset();
        do_reset();
        run_instr(12'h825, 0, 0, 0);
        run_instr(12'h847, 1, 0, 0);
        #2 rst = 1'b1; #1;
        checks++; if (pc !== '0) begin failures++; $display("FAIL rst_pc: got %0h exp 0", pc); end
        checks++; if (alu_out !== '0) begin failures++; $display("FAIL rst_alu_out: got %0h exp 0", alu_out); end
        checks++; if (dataout !== '0) begin failures++; $display("FAIL rst_dataout: got %0h exp 0", dataout); end
        checks++; if ({wr, rd, retire} !== 3'b000) begin failures++; $display("FAIL rst_strobes: got %b%b%b exp 000", wr, rd, retire); end
        for (int r = 1; r < 4; r++) begin
            dbg_addr = AW'(r); #1;
            checks++; if (dbg_data !== '0) begin failures++; $display("FAIL rst_R%0d: got %0h exp 0", r, dbg_data); end
        end
        @(posedge clk); #1;
        rst = 1'b0;
        model_clear();
    endtask

    task automatic test_addi();
        do_reset();
        run_instr(12'h825, 0, 0, 0);
        dbg_addr = 2'd1; #1;
        checks++; if (dbg_data !== 5'd5) begin failures++; $display("FAIL addi_R1: got %0h exp 5", dbg_data); end
        checks++; if (pc !== 5'd2) begin failures++; $display("FAIL addi_pc: got %0h exp 2", pc); end
    endtask

    task automatic test_alu_xor();
        run_instr(12'h6B4, 0, 0, 0);
        dbg_addr = 2'd2; #1;
        checks++; if (dbg_data !== 5'd0) begin failures++; $display("FAIL xor_R2_a: got %0h exp 0", dbg_data); end
        run_instr(12'h847, 0, 0, 0);
        dbg_addr = 2'd2; #1;
        checks++; if (dbg_data !== 5'd7) begin failures++; $display("FAIL preload_R2: got %0h exp 7", dbg_data); end
        run_instr(12'h6B4, 0, 0, 0);
        dbg_addr = 2'd2; #1;
        checks++; if (dbg_data !== 5'd0) begin failures++; $display("FAIL xor_R2_b: got %0h exp 0", dbg_data); end
    endtask

    task automatic test_branch();
        do_reset();
        run_instr(12'h403, 0, 0, 0);
        checks++; if (pc !== 5'd8) begin failures++; $display("FAIL beqz_pc: got %0h exp 8", pc); end
        do_reset();
        run_instr(12'hC03, 0, 0, 0);
        checks++; if (pc !== 5'd2) begin failures++; $display("FAIL bnez_pc: got %0h exp 2", pc); end
    endtask

    task automatic test_sw_stall();
        int wc0, c0;
        do_reset();
        run_instr(12'h825, 0, 0, 0);
        run_instr(12'h847, 0, 0, 0);
        wc0 = wr_cnt; c0 = cyc;
        run_instr(12'h2C3, 0, 3, 0);
        checks++; if (wr_cnt - wc0 !== 4) begin failures++; $display("FAIL sw_wr_cycles: got %0d exp 4", wr_cnt - wc0); end
        checks++; if (cyc - c0 !== 8) begin failures++; $display("FAIL sw_latency: got %0d exp 8", cyc - c0); end
        checks++; if (alu_out !== 5'd8) begin failures++; $display("FAIL sw_addr: got %0h exp 8", alu_out); end
    endtask

    task automatic test_subi();
        do_reset();
        run_instr(12'hA21, 0, 0, 0);
        dbg_addr = 2'd1; #1;
        checks++; if (dbg_data !== 5'h1F) begin failures++; $display("FAIL subi_R1: got %0h exp 1f", dbg_data); end
    endtask

    task automatic test_imm_ext();
        do_reset();
        run_instr(12'h83F, 0, 0, 0);
        dbg_addr = 2'd1; #1;
        checks++; if (dbg_data !== 5'h1F) begin failures++; $display("FAIL zext5_R1: got %0h exp 1f", dbg_data); end
        checks++; if (sx_dbg_data !== 5'h1F) begin failures++; $display("FAIL sext5_R1: got %0h exp 1f", sx_dbg_data); end
        checks++; if (w8_dbg_data !== 8'h1F) begin failures++; $display("FAIL zext8_R1: got %0h exp 1f", w8_dbg_data); end
    endtask

    task automatic abort_case(input logic [11:0] ins, input int n_edges, input logic exp_rd);
        int rc0;
        do_reset();
        rc0 = retire_cnt;
        instruction = ins; imem_ready = 1'b1; mem_ready = 1'b0;
        repeat (n_edges) begin @(posedge clk); #1; imem_ready = 1'b0; datain = DW'($urandom); end
        checks++; if (rd !== exp_rd) begin failures++; $display("FAIL abort_pre_rd: got %b exp %b", rd, exp_rd); end
        #2 rst = 1'b1; #1;
        checks++; if (pc !== '0) begin failures++; $display("FAIL abort_pc: got %0h exp 0", pc); end
        checks++; if ({rd, wr, retire} !== 3'b000) begin failures++; $display("FAIL abort_strobes: got %b%b%b exp 000", rd, wr, retire); end
        checks++; if (alu_out !== '0) begin failures++; $display("FAIL abort_alu_out: got %0h exp 0", alu_out); end
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        checks++; if (retire_cnt !== rc0) begin failures++; $display("FAIL abort_retire: got %0d exp %0d", retire_cnt, rc0); end
        dbg_addr = 2'd1; #1;
        checks++; if (dbg_data !== '0) begin failures++; $display("FAIL abort_R1: got %0h exp 0", dbg_data); end
        model_clear();
        run_instr(12'h825, 0, 0, 0);
    endtask

    task automatic test_reset_abort();
        abort_case(12'h825, 2, 1'b0);   // reset during EX of ADDI
        abort_case(12'h022, 4, 1'b1);   // reset during a stalled LW MEM
    endtask

    task automatic test_random();
        do_reset();
        for (int n = 0; n < 80; n++) begin
            run_instr(IW'($urandom), $urandom_range(0, 2), $urandom_range(0, 2), int'($urandom_range(0, 31)));
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete within time limit");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_addi();
        test_alu_xor();
        test_branch();
        test_sw_stall();
        test_subi();
        test_imm_ext();
        test_reset_abort();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
